// File: rtl/avg_line_sink.sv
// rtl/avg_line_sink.sv - line reassembly sink with ping-pong line store, line sum and host read port
//
// Ports:
//   clk, arstn               clock, asynchronous active-low reset
//   din_data, din_valid      filtered pixel stream, no backpressure
//   col, row                 position the next accepted pixel will occupy
//   line_done, line_sum      commit pulse and sum of the committed line
//   frame_done               pulse with line_done of the last row of a frame
//   rd_avail, rd_bank        a committed line is waiting, and which bank holds the oldest
//   rd_en, rd_addr, rd_data  registered read port (1-cycle latency)
//   rd_release               frees rd_bank
//   overflow                 sticky: a pixel was dropped because the write bank was full

module avg_line_sink #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 4,
    parameter int SUM_WIDTH    = PIXEL_WIDTH + $clog2(IMAGE_WIDTH)
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [PIXEL_WIDTH-1:0]            din_data,
    input  logic                              din_valid,
    output logic [$clog2(IMAGE_WIDTH)-1:0]    col,
    output logic [$clog2(IMAGE_HEIGHT+1)-1:0] row,
    output logic                              line_done,
    output logic [SUM_WIDTH-1:0]              line_sum,
    output logic                              frame_done,
    output logic                              rd_avail,
    output logic                              rd_bank,
    input  logic                              rd_en,
    input  logic [$clog2(IMAGE_WIDTH)-1:0]    rd_addr,
    output logic [PIXEL_WIDTH-1:0]            rd_data,
    input  logic                              rd_release,
    output logic                              overflow
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW:0]   ADDR_LIM = (CW + 1)'(IMAGE_WIDTH);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t bank_st     [2];
    bank_state_t bank_st_nxt [2];
    logic [1:0]  bank_full;

    logic [PIXEL_WIDTH-1:0] mem [0:1][0:IMAGE_WIDTH-1];

    logic                 wbank;
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] pix_ext;
    logic                 accept;
    logic                 drop;
    logic                 last_col;
    logic                 commit;
    logic                 release_ok;

    // Acceptance looks at the registered bank state, so a release in the
    // same cycle as an incoming pixel does not rescue that pixel.
    assign pix_ext    = {{(SUM_WIDTH - PIXEL_WIDTH){1'b0}}, din_data};
    assign accept     = din_valid && !bank_full[wbank];
    assign drop       = din_valid &&  bank_full[wbank];
    assign last_col   = (col == COL_LAST);
    assign commit     = accept && last_col;
    assign release_ok = rd_release && rd_avail;

    // Bank FSM: state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
        end
    end

    // Bank FSM: next state. Release and write can never target the same bank
    // (release needs FULL, write needs not FULL), so the order is immaterial.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b] = bank_st[b];
            if (release_ok && (rd_bank == 1'(b))) begin
                bank_st_nxt[b] = BANK_EMPTY;
            end
            if (accept && (wbank == 1'(b))) begin
                bank_st_nxt[b] = last_col ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    // Bank FSM: outputs
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_full[b] = (bank_st[b] == BANK_FULL);
        end
    end

    assign rd_avail = |bank_full;

    // Line store has no reset; contents of a non-committed bank are simply stale.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][col] <= din_data;
        end
    end

    // Banks fill strictly alternately and are released in commit order, so the
    // oldest full bank is tracked by toggling on each release; when nothing is
    // full it already points at the bank that will commit next.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            col        <= '0;
            row        <= '0;
            acc        <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            line_sum   <= '0;
            wbank      <= 1'b0;
            rd_bank    <= 1'b0;
            rd_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            line_done  <= commit;
            frame_done <= commit && (row == ROW_LAST);

            if (accept) begin
                if (last_col) begin
                    col      <= '0;
                    acc      <= '0;
                    line_sum <= acc + pix_ext;
                    wbank    <= ~wbank;
                    row      <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                    acc <= acc + pix_ext;
                end
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (release_ok) begin
                rd_bank <= ~rd_bank;
            end

            if (rd_en) begin
                if ({1'b0, rd_addr} < ADDR_LIM) begin
                    rd_data <= mem[rd_bank][rd_addr];
                end else begin
                    rd_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_line_sink.sv
// tb/tb_avg_line_sink.sv - directed self-checking bench for avg_line_sink

module tb_avg_line_sink;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [7:0]  din_data = '0;
    logic        din_valid = 1'b0;
    logic [6:0]  col;
    logic [2:0]  row;
    logic        line_done;
    logic [14:0] line_sum;
    logic        frame_done;
    logic        rd_avail;
    logic        rd_bank;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_release = 1'b0;
    logic        overflow;

    // Narrow instance (100-pixel lines) so an out-of-range read address is expressible.
    logic [6:0]  np_col;
    logic [1:0]  np_row;
    logic        np_line_done;
    logic [14:0] np_line_sum;
    logic        np_frame_done;
    logic        np_rd_avail;
    logic        np_rd_bank;
    logic        np_rd_en = 1'b0;
    logic [6:0]  np_rd_addr = '0;
    logic [7:0]  np_rd_data;
    logic        np_overflow;

    int checks = 0;
    int failures = 0;
    int ld_cnt = 0;
    int fd_cnt = 0;
    int exp_sum = 8256;
    int cur_mode = 0;
    bit auto_rel = 1'b0;
    bit rchk = 1'b0;
    int rexp = 0;

    always #5 clk = ~clk;

    avg_line_sink #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(128), .IMAGE_HEIGHT(4)) u_dut (
        .clk(clk), .arstn(arstn), .din_data(din_data), .din_valid(din_valid),
        .col(col), .row(row), .line_done(line_done), .line_sum(line_sum),
        .frame_done(frame_done), .rd_avail(rd_avail), .rd_bank(rd_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_release(rd_release), .overflow(overflow)
    );

    avg_line_sink #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(100), .IMAGE_HEIGHT(2)) u_np (
        .clk(clk), .arstn(arstn), .din_data(din_data), .din_valid(din_valid),
        .col(np_col), .row(np_row), .line_done(np_line_done), .line_sum(np_line_sum),
        .frame_done(np_frame_done), .rd_avail(np_rd_avail), .rd_bank(np_rd_bank),
        .rd_en(np_rd_en), .rd_addr(np_rd_addr), .rd_data(np_rd_data),
        .rd_release(1'b0), .overflow(np_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; pulses (rd_en, rd_release) last exactly one cycle. When the
    // host model is active it reads one pixel of each committed line and
    // releases that line on the cycle line_done is seen.
    task automatic cycle();
        int k;
        @(posedge clk);
        #1;
        if (rchk) begin
            chk("host_rd_data", rd_data, rexp);
            rchk = 1'b0;
        end
        rd_en = 1'b0;
        rd_release = 1'b0;
        if (line_done) begin
            ld_cnt++;
            if (frame_done) fd_cnt++;
            chk("line_sum", line_sum, exp_sum);
            if (auto_rel) begin
                k = (ld_cnt * 5 + 3) % 128;
                rd_en = 1'b1;
                rd_addr = 7'(k);
                rd_release = 1'b1;
                rexp = (cur_mode == 0) ? k + 1 : 255;
                rchk = 1'b1;
            end
        end
    endtask

    task automatic stream(input int n, input int start, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) cycle();
            din_valid = 1'b1;
            din_data = (cur_mode == 0) ? 8'(((start + i) % 128) + 1) : 8'd255;
            cycle();
            din_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        din_valid = 1'b0;
        rd_en = 1'b0;
        rd_release = 1'b0;
        np_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        ld_cnt = 0;
        fd_cnt = 0;
        rchk = 1'b0;
    endtask

    initial begin
        // T1: reset values, one frame with host releasing each line
        do_reset();
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_line_sum", line_sum, 0);
        chk("rst_rd_avail", rd_avail, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        cur_mode = 0; exp_sum = 8256; auto_rel = 1'b1;
        stream(512, 0, 1'b0);
        cycle(); cycle();
        chk("t1_line_cnt", ld_cnt, 4);
        chk("t1_frame_cnt", fd_cnt, 1);
        chk("t1_overflow", overflow, 0);
        chk("t1_row_wrap", row, 0);
        chk("t1_rd_avail", rd_avail, 0);

        // T2: no release, third line dropped
        do_reset();
        auto_rel = 1'b0;
        stream(384, 0, 1'b0);
        chk("t2_line_cnt", ld_cnt, 2);
        chk("t2_rd_avail", rd_avail, 1);
        chk("t2_overflow", overflow, 1);
        chk("t2_col_hold", col, 0);
        chk("t2_row", row, 2);
        chk("t2_rd_bank", rd_bank, 0);
        rd_release = 1'b1; cycle();
        chk("t2_rd_bank_rel1", rd_bank, 1);
        chk("t2_overflow_rel1", overflow, 1);
        rd_release = 1'b1; cycle();
        chk("t2_rd_avail_rel2", rd_avail, 0);
        chk("t2_overflow_rel2", overflow, 1);
        stream(128, 0, 1'b0);
        chk("t2_resume_cnt", ld_cnt, 3);
        chk("t2_resume_row", row, 3);
        chk("t2_resume_bank", rd_bank, 0);

        // T3: two frames of 255 with random gaps
        do_reset();
        cur_mode = 1; exp_sum = 32640; auto_rel = 1'b1;
        stream(1024, 0, 1'b1);
        cycle(); cycle();
        chk("t3_line_cnt", ld_cnt, 8);
        chk("t3_frame_cnt", fd_cnt, 2);
        chk("t3_row_wrap", row, 0);
        chk("t3_overflow", overflow, 0);

        // T4: release coincident with commit while the other bank is full
        do_reset();
        cur_mode = 0; exp_sum = 8256; auto_rel = 1'b0;
        stream(128, 0, 1'b0);
        chk("t4_rd_bank0", rd_bank, 0);
        stream(127, 0, 1'b0);
        din_valid = 1'b1; din_data = 8'd128; rd_release = 1'b1;
        cycle();
        din_valid = 1'b0;
        chk("t4_line_done", line_done, 1);
        chk("t4_rd_bank_switch", rd_bank, 1);
        chk("t4_rd_avail", rd_avail, 1);
        stream(128, 0, 1'b0);
        chk("t4_next_line_cnt", ld_cnt, 3);
        chk("t4_no_drop", overflow, 0);
        chk("t4_oldest_bank", rd_bank, 1);
        rd_en = 1'b1; rd_addr = 7'd10;
        cycle();
        chk("t4_rd_bank1_data", rd_data, 11);

        // T5: asynchronous reset after 60 pixels
        do_reset();
        cur_mode = 1;
        stream(60, 0, 1'b0);
        chk("t5_col_pre", col, 60);
        #2;
        arstn = 1'b0;
        #1;
        chk("t5_async_col", col, 0);
        chk("t5_async_row", row, 0);
        chk("t5_async_rd_avail", rd_avail, 0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        ld_cnt = 0;
        cur_mode = 0; exp_sum = 8256;
        stream(127, 0, 1'b0);
        chk("t5_no_early_line", ld_cnt, 0);
        stream(1, 127, 1'b0);
        chk("t5_line_after_128", ld_cnt, 1);

        // T6: read hold and out-of-range address
        rd_en = 1'b1; rd_addr = 7'd7;
        np_rd_en = 1'b1; np_rd_addr = 7'd120;
        cycle();
        chk("t6_rd_data", rd_data, 8);
        chk("t6_np_oor", np_rd_data, 0);
        rd_addr = 7'd9;
        np_rd_en = 1'b1; np_rd_addr = 7'd50;
        cycle();
        chk("t6_rd_hold", rd_data, 8);
        chk("t6_np_in_range", np_rd_data, 51);
        np_rd_en = 1'b0; np_rd_addr = 7'd120;
        cycle();
        chk("t6_np_hold", np_rd_data, 51);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
